// File: rtl/pll_vdc_reconfig.sv
// pll_vdc_reconfig
//   Retunes the VDC pixel-clock PLL (50 MHz ref, 576 MHz fractional VCO)
//   through the Avalon-MM management port of the PLL reconfig core.
//   When the video-mode select differs from the programmed profile, the
//   VDC clock enable is gated and the mode, M, K, C0 and START registers
//   are written in turn. The controller then waits for the PLL to lock
//   before ungating.
//
// Ports
//   clk              50 MHz management clock
//   reset_n          asynchronous active-low reset
//   sel              requested profile (asynchronous, synchronised here)
//   pll_locked       PLL lock indicator (asynchronous, synchronised here)
//   mgmt_address     reconfig register address
//   mgmt_write       write strobe
//   mgmt_writedata   write data
//   mgmt_waitrequest reconfig core stall
//   vdc_hold         1 = gate the VDC clock enable
//   busy             reconfiguration in progress
//   error            sticky lock-timeout flag
//   cur_profile      profile currently programmed
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for sel_s to differ from cur_profile
// WR_MODE    | write 0x00 <= 0 (waitrequest mode)
// WR_M       | write 0x04 <= M word of target profile
// WR_K       | write 0x07 <= fractional K of target profile
// WR_C       | write 0x05 <= C0 word of target profile
// WR_START   | write 0x02 <= 1 (start reconfiguration)
// SETTLE     | let the PLL drop lock, lock ignored for SETTLE_CYC cycles
// WAIT_LOCK  | wait for lock or timeout
// DONE       | release hold and busy, then back to IDLE

module pll_vdc_reconfig #(
    parameter logic [31:0] M0_WORD      = 32'h0002_0605,
    parameter logic [31:0] K0_WORD      = 32'd2233382994,
    parameter logic [31:0] C0_WORD0     = 32'h0000_0909,
    parameter logic [31:0] M1_WORD      = 32'h0002_0605,
    parameter logic [31:0] K1_WORD      = 32'd2233382994,
    parameter logic [31:0] C0_WORD1     = 32'h0000_1212,
    parameter int          SETTLE_CYC   = 64,
    parameter int          LOCK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    output logic        vdc_hold,
    output logic        busy,
    output logic        error,
    output logic        cur_profile
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_MODE, S_WR_M, S_WR_K, S_WR_C, S_WR_START,
        S_SETTLE, S_WAIT_LOCK, S_DONE
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);

    logic [1:0]  sel_sync, lock_sync;
    logic        sel_s, lock_s;

    state_t      state, state_nxt;
    logic        tgt, tgt_nxt;
    logic [7:0]  settle_cnt, settle_cnt_nxt;
    logic [19:0] lock_cnt, lock_cnt_nxt;
    logic [5:0]  addr_nxt;
    logic        write_nxt;
    logic [31:0] data_nxt;
    logic        vdc_hold_nxt, busy_nxt, error_nxt, cur_profile_nxt;

    // Following write in the sequence (address, data, state) for the gap cycle.
    state_t      seq_state;
    logic [5:0]  seq_addr;
    logic [31:0] seq_data;

    assign sel_s  = sel_sync[1];
    assign lock_s = lock_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_sync       <= '0;
            lock_sync      <= '0;
            state          <= S_IDLE;
            tgt            <= 1'b0;
            settle_cnt     <= '0;
            lock_cnt       <= '0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_writedata <= '0;
            vdc_hold       <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
            cur_profile    <= 1'b0;
        end else begin
            sel_sync       <= {sel_sync[0], sel};
            lock_sync      <= {lock_sync[0], pll_locked};
            state          <= state_nxt;
            tgt            <= tgt_nxt;
            settle_cnt     <= settle_cnt_nxt;
            lock_cnt       <= lock_cnt_nxt;
            mgmt_address   <= addr_nxt;
            mgmt_write     <= write_nxt;
            mgmt_writedata <= data_nxt;
            vdc_hold       <= vdc_hold_nxt;
            busy           <= busy_nxt;
            error          <= error_nxt;
            cur_profile    <= cur_profile_nxt;
        end
    end

    always_comb begin
        seq_state = S_SETTLE;
        seq_addr  = 6'h00;
        seq_data  = 32'd0;
        case (state)
            S_WR_MODE: begin
                seq_state = S_WR_M;
                seq_addr  = 6'h04;
                seq_data  = tgt ? M1_WORD : M0_WORD;
            end
            S_WR_M: begin
                seq_state = S_WR_K;
                seq_addr  = 6'h07;
                seq_data  = tgt ? K1_WORD : K0_WORD;
            end
            S_WR_K: begin
                seq_state = S_WR_C;
                seq_addr  = 6'h05;
                seq_data  = tgt ? C0_WORD1 : C0_WORD0;
            end
            S_WR_C: begin
                seq_state = S_WR_START;
                seq_addr  = 6'h02;
                seq_data  = 32'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        tgt_nxt         = tgt;
        settle_cnt_nxt  = settle_cnt;
        lock_cnt_nxt    = lock_cnt;
        addr_nxt        = mgmt_address;
        write_nxt       = mgmt_write;
        data_nxt        = mgmt_writedata;
        vdc_hold_nxt    = vdc_hold;
        busy_nxt        = busy;
        error_nxt       = error;
        cur_profile_nxt = cur_profile;

        case (state)
            S_IDLE: begin
                if (sel_s != cur_profile) begin
                    tgt_nxt      = sel_s;
                    busy_nxt     = 1'b1;
                    vdc_hold_nxt = 1'b1;
                    state_nxt    = S_WR_MODE;
                    write_nxt    = 1'b1;
                    addr_nxt     = 6'h00;
                    data_nxt     = 32'd0;
                end
            end
            S_WR_MODE, S_WR_M, S_WR_K, S_WR_C, S_WR_START: begin
                if (mgmt_write) begin
                    // Strobe phase: hold everything until the core accepts.
                    if (!mgmt_waitrequest)
                        write_nxt = 1'b0;
                end else begin
                    // Gap phase: one idle cycle, then launch the next write.
                    state_nxt = seq_state;
                    if (state == S_WR_START) begin
                        settle_cnt_nxt = '0;
                    end else begin
                        write_nxt = 1'b1;
                        addr_nxt  = seq_addr;
                        data_nxt  = seq_data;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_nxt = '0;
                    lock_cnt_nxt   = '0;
                    state_nxt      = S_WAIT_LOCK;
                end else if (settle_cnt != '1) begin
                    settle_cnt_nxt = settle_cnt + 8'd1;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is tested first so it wins on the terminal-count cycle.
                if (lock_s) begin
                    cur_profile_nxt = tgt;
                    error_nxt       = 1'b0;
                    state_nxt       = S_DONE;
                end else if (lock_cnt == LOCK_LAST) begin
                    cur_profile_nxt = tgt;
                    error_nxt       = 1'b1;
                    state_nxt       = S_DONE;
                end else if (lock_cnt != '1) begin
                    lock_cnt_nxt = lock_cnt + 20'd1;
                end
            end
            S_DONE: begin
                vdc_hold_nxt   = 1'b0;
                busy_nxt       = 1'b0;
                settle_cnt_nxt = '0;
                lock_cnt_nxt   = '0;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pll_vdc_reconfig.sv
// tb_pll_vdc_reconfig
//   Directed bench for pll_vdc_reconfig. A passive monitor logs every
//   accepted management write with its cycle stamp and flags strobe
//   instability under waitrequest and back-to-back strobes. Lock timeout
//   is shortened to 200 cycles to keep the run short.

module tb_pll_vdc_reconfig;

    localparam int LT = 200;
    localparam int SC = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic        vdc_hold, busy, error, cur_profile;

    int n_cmp = 0;
    int n_err = 0;

    pll_vdc_reconfig #(.LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .pll_locked(pll_locked),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
        .vdc_hold(vdc_hold), .busy(busy), .error(error), .cur_profile(cur_profile)
    );

    always #10 clk = ~clk;

    // Monitor: values read at posedge are the pre-edge values.
    logic [5:0]  q_addr[$];
    logic [31:0] q_data[$];
    int          q_ts[$];
    int          cyc = 0;
    int          fall_ts = 0;
    int          stab_err = 0, b2b_err = 0, k_cycles = 0, wr_cycles = 0;
    bit          p_stall = 0, p_acc = 0, p_busy = 0;
    logic [5:0]  p_addr = '0;
    logic [31:0] p_data = '0;

    always @(posedge clk) begin
        if (p_stall && (mgmt_write !== 1'b1 || mgmt_address !== p_addr || mgmt_writedata !== p_data))
            stab_err++;
        if (p_acc && mgmt_write === 1'b1) b2b_err++;
        if (mgmt_write === 1'b1) wr_cycles++;
        if (mgmt_write === 1'b1 && mgmt_address === 6'h07) k_cycles++;
        if (mgmt_write === 1'b1 && mgmt_waitrequest === 1'b0) begin
            q_addr.push_back(mgmt_address);
            q_data.push_back(mgmt_writedata);
            q_ts.push_back(cyc);
        end
        if (p_busy && busy === 1'b0) fall_ts = cyc;
        p_stall = (mgmt_write === 1'b1) && (mgmt_waitrequest === 1'b1);
        p_acc   = (mgmt_write === 1'b1) && (mgmt_waitrequest === 1'b0);
        p_addr  = mgmt_address;
        p_data  = mgmt_writedata;
        p_busy  = (busy === 1'b1);
        cyc++;
    end

    task automatic clear_log();
        q_addr.delete(); q_data.delete(); q_ts.delete();
        k_cycles = 0;
    endtask

    // Waits for busy to rise (if not already) and then fall; ok=0 on expiry.
    task automatic wait_seq(input int max_cyc, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (busy === 1'b1) begin
            n = 0;
            while (busy !== 1'b0 && n < max_cyc) begin @(negedge clk); n++; end
            ok = (busy === 1'b0);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sel = 1'b0; pll_locked = 1'b1; mgmt_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mgmt_address, mgmt_write, mgmt_writedata, vdc_hold, busy, error, cur_profile} !== 44'd0) begin
            n_err++;
            $display("FAIL reset_values: got addr=%h wr=%b data=%h hold=%b busy=%b err=%b cur=%b, want all 0",
                     mgmt_address, mgmt_write, mgmt_writedata, vdc_hold, busy, error, cur_profile);
        end
        reset_n = 1'b1;
        wr_cycles = 0;
        repeat (1000) @(negedge clk);
        n_cmp++;
        if (wr_cycles !== 0) begin
            n_err++; $display("FAIL idle_no_write: got %0d write cycles, want 0", wr_cycles);
        end
        n_cmp++;
        if ({busy, vdc_hold, cur_profile, error} !== 4'b0000) begin
            n_err++; $display("FAIL idle_flags: got busy/hold/cur/err=%b%b%b%b, want 0000", busy, vdc_hold, cur_profile, error);
        end
    endtask

    task automatic test_switch_to_1();
        logic [5:0]  ea [5] = '{6'h00, 6'h04, 6'h07, 6'h05, 6'h02};
        logic [31:0] ed [5] = '{32'd0, 32'h0002_0605, 32'h851E_B852, 32'h0000_1212, 32'd1};
        bit ok;
        clear_log();
        sel = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({busy, vdc_hold} !== 2'b11) begin
            n_err++; $display("FAIL s1_hold_on: got busy/hold=%b%b, want 11", busy, vdc_hold);
        end
        wait_seq(300, ok);
        @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL s1_complete: busy did not clear, got ok=%b want 1", ok); end
        n_cmp++;
        if (q_addr.size() !== 5) begin
            n_err++; $display("FAIL s1_count: got %0d writes, want 5", q_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (q_addr[i] !== ea[i] || q_data[i] !== ed[i]) begin
                    n_err++; $display("FAIL s1_write%0d: got (%h,%h), want (%h,%h)", i, q_addr[i], q_data[i], ea[i], ed[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (q_ts[i+1] - q_ts[i] !== 2) begin
                    n_err++; $display("FAIL s1_spacing%0d: got %0d cycles, want 2", i, q_ts[i+1] - q_ts[i]);
                end
            end
            n_cmp++;
            if (fall_ts - q_ts[4] !== SC + 4) begin
                n_err++; $display("FAIL s1_settle: got %0d cycles START->idle, want %0d", fall_ts - q_ts[4], SC + 4);
            end
        end
        n_cmp++;
        if ({cur_profile, vdc_hold, error} !== 3'b100) begin
            n_err++; $display("FAIL s1_final: got cur/hold/err=%b%b%b, want 100", cur_profile, vdc_hold, error);
        end
        n_cmp++;
        if (b2b_err !== 0) begin n_err++; $display("FAIL s1_b2b: got %0d back-to-back strobes, want 0", b2b_err); end
    endtask

    task automatic test_waitrequest();
        logic [5:0]  ea [5] = '{6'h00, 6'h04, 6'h07, 6'h05, 6'h02};
        logic [31:0] ed [5] = '{32'd0, 32'h0002_0605, 32'h851E_B852, 32'h0000_0909, 32'd1};
        bit ok;
        int n = 0;
        clear_log();
        stab_err = 0;
        sel = 1'b0;
        while (!(mgmt_write === 1'b1 && mgmt_address === 6'h07) && n < 50) begin @(negedge clk); n++; end
        mgmt_waitrequest = 1'b1;
        repeat (5) @(negedge clk);
        mgmt_waitrequest = 1'b0;
        wait_seq(300, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL wr_complete: got ok=%b want 1", ok); end
        n_cmp++;
        if (k_cycles !== 6) begin n_err++; $display("FAIL wr_k_cycles: got %0d strobe cycles on 0x07, want 6", k_cycles); end
        n_cmp++;
        if (stab_err !== 0) begin n_err++; $display("FAIL wr_stable: got %0d unstable cycles, want 0", stab_err); end
        n_cmp++;
        if (q_addr.size() !== 5) begin
            n_err++; $display("FAIL wr_count: got %0d accepted writes, want 5", q_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (q_addr[i] !== ea[i] || q_data[i] !== ed[i]) begin
                    n_err++; $display("FAIL wr_write%0d: got (%h,%h), want (%h,%h)", i, q_addr[i], q_data[i], ea[i], ed[i]);
                end
            end
        end
        n_cmp++;
        if (cur_profile !== 1'b0) begin n_err++; $display("FAIL wr_cur: got %b want 0", cur_profile); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        clear_log();
        pll_locked = 1'b0;
        sel = 1'b1;
        wait_seq(LT + SC + 100, ok);
        @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL to_complete: got ok=%b want 1", ok); end
        n_cmp++;
        if ({error, vdc_hold, cur_profile} !== 3'b101) begin
            n_err++; $display("FAIL to_flags: got err/hold/cur=%b%b%b, want 101", error, vdc_hold, cur_profile);
        end
        n_cmp++;
        if (q_ts.size() !== 5 || fall_ts - q_ts[q_ts.size()-1] !== LT + SC + 3) begin
            n_err++; $display("FAIL to_timing: got %0d writes, %0d cycles START->idle, want 5, %0d",
                              q_ts.size(), (q_ts.size() > 0) ? fall_ts - q_ts[q_ts.size()-1] : -1, LT + SC + 3);
        end
        pll_locked = 1'b1;
        sel = 1'b0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_cmp++;
        if ({busy, error} !== 2'b11) begin
            n_err++; $display("FAIL to_sticky: got busy/err=%b%b mid-sequence, want 11", busy, error);
        end
        wait_seq(300, ok);
        n_cmp++;
        if ({ok, error, cur_profile} !== 3'b100) begin
            n_err++; $display("FAIL to_clear: got ok/err/cur=%b%b%b, want 100", ok, error, cur_profile);
        end
    endtask

    task automatic test_toggle_mid();
        bit ok;
        int n = 0;
        clear_log();
        sel = 1'b1;
        while (!(mgmt_write === 1'b1 && mgmt_address === 6'h04) && n < 50) begin @(negedge clk); n++; end
        sel = 1'b0;
        wait_seq(300, ok);
        n_cmp++;
        if ({ok, cur_profile} !== 2'b11) begin
            n_err++; $display("FAIL tg_first: got ok/cur=%b%b, want 11", ok, cur_profile);
        end
        wait_seq(300, ok);
        n_cmp++;
        if ({ok, cur_profile} !== 2'b10) begin
            n_err++; $display("FAIL tg_second: got ok/cur=%b%b, want 10", ok, cur_profile);
        end
        n_cmp++;
        if (q_data.size() !== 10 || q_data[3] !== 32'h1212 || q_data[8] !== 32'h909 || q_addr[8] !== 6'h05) begin
            n_err++; $display("FAIL tg_writes: got %0d writes (C words %h/%h), want 10 (00001212/00000909)",
                              q_data.size(), (q_data.size() > 3) ? q_data[3] : 32'hx, (q_data.size() > 8) ? q_data[8] : 32'hx);
        end
    endtask

    task automatic test_lock_boundary();
        bit ok;
        int n = 0;
        clear_log();
        pll_locked = 1'b0;
        sel = 1'b1;
        while (!(q_addr.size() > 0 && q_addr[q_addr.size()-1] === 6'h02) && n < 100) begin @(negedge clk); n++; end
        // Lock reaches lock_s exactly on the terminal-count cycle.
        repeat (LT + SC - 2) @(negedge clk);
        pll_locked = 1'b1;
        wait_seq(300, ok);
        n_cmp++;
        if ({ok, error, cur_profile} !== 3'b101) begin
            n_err++; $display("FAIL lb_lock_wins: got ok/err/cur=%b%b%b, want 101", ok, error, cur_profile);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        sel = 1'b0;
        while (!(mgmt_write === 1'b1 && mgmt_address === 6'h05) && n < 50) begin @(negedge clk); n++; end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mgmt_write, busy, vdc_hold, cur_profile} !== 4'b0000) begin
            n_err++; $display("FAIL rm_async: got wr/busy/hold/cur=%b%b%b%b, want 0000", mgmt_write, busy, vdc_hold, cur_profile);
        end
        sel = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        reset_n = 1'b1;
        wait_seq(300, ok);
        n_cmp++;
        if ({ok, cur_profile} !== 2'b11) begin
            n_err++; $display("FAIL rm_restart: got ok/cur=%b%b, want 11", ok, cur_profile);
        end
        n_cmp++;
        if (q_addr.size() !== 5 || q_addr[0] !== 6'h00 || q_data[3] !== 32'h1212) begin
            n_err++; $display("FAIL rm_sequence: got %0d writes first addr %h, want 5 from 00",
                              q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 6'hx);
        end
        n_cmp++;
        if (b2b_err !== 0) begin n_err++; $display("FAIL rm_b2b: got %0d back-to-back strobes, want 0", b2b_err); end
    endtask

    initial begin
        test_reset();
        test_switch_to_1();
        test_waitrequest();
        test_timeout();
        test_toggle_mid();
        test_lock_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want finish before limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_vdc_reconfig.md
Name: pll_vdc_reconfig

Overview:
- Reconfiguration controller for the VDC pixel-clock PLL: 50 MHz reference, fractional VCO 576 MHz, outclk_0 = 32 MHz.
- Drives the Avalon-MM management port of the Cyclone V PLL reconfig core, switching outclk_0 between two precomputed profiles on request from the core's video-mode logic.
- Holds the VDC clock enable off while the PLL retunes, then releases it once lock is regained.
- Runs on the 50 MHz management clock.

Parameters:
- M0_WORD, 32'h0002_0605, profile 0 M counter word (odd=1, hi=6, lo=5).
- K0_WORD, 32'd2233382994, profile 0 fractional K.
- C0_WORD0, 32'h0000_0909, profile 0 C0 counter word (select 0, hi=9, lo=9 => 32 MHz).
- M1_WORD, 32'h0002_0605, profile 1 M counter word.
- K1_WORD, 32'd2233382994, profile 1 fractional K.
- C0_WORD1, 32'h0000_1212, profile 1 C0 counter word (hi=18, lo=18 => 16 MHz).
- SETTLE_CYC, 64, cycles waited after START before sampling lock.
- LOCK_TIMEOUT, 1000000, maximum cycles to wait for lock (20 ms).

Ports:
- clk  in  1  50 MHz management clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- sel  in  1  requested profile, asynchronous to clk.
- pll_locked  in  1  PLL locked output, asynchronous.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_waitrequest  in  1  reconfig core stall.
- vdc_hold  out  1  1 = gate VDC clock enable.
- busy  out  1  reconfiguration in progress.
- error  out  1  sticky lock-timeout flag.
- cur_profile  out  1  profile currently programmed.

Behaviour:
- Reset values: mgmt_address=0, mgmt_write=0, mgmt_writedata=0, vdc_hold=0, busy=0, error=0, cur_profile=0, state=IDLE, counters=0.
- sel and pll_locked each pass through a 2-flop synchroniser; sel_s and lock_s are the synchronised versions.
- IDLE:
  - If sel_s != cur_profile, latch tgt=sel_s, set busy=1 and vdc_hold=1, go to WR_MODE.
  - A request is seen 2-3 cycles after sel toggles.
- Write states, in order:
  - WR_MODE: addr 0x00, data 0 (waitrequest mode).
  - WR_M: addr 0x04, data M{tgt}.
  - WR_K: addr 0x07, data K{tgt}.
  - WR_C: addr 0x05, data C0_WORD{tgt}.
  - WR_START: addr 0x02, data 1.
- Write handshake:
  - On entry, mgmt_write=1 with address and data valid in the same cycle.
  - All three are held stable while mgmt_waitrequest=1.
  - The write completes on the first rising edge with mgmt_write=1 and mgmt_waitrequest=0.
  - The next cycle deasserts mgmt_write for exactly one cycle before the next write; no back-to-back strobes.
  - With mgmt_waitrequest tied low, a write occupies 2 cycles.
- SETTLE: count SETTLE_CYC cycles, ignoring lock_s, then go to WAIT_LOCK.
- WAIT_LOCK:
  - Counter increments each cycle.
  - If lock_s=1: cur_profile<=tgt, error<=0, go to DONE.
  - If counter reaches LOCK_TIMEOUT-1 and lock_s=1 on that same cycle, lock wins.
  - If counter reaches LOCK_TIMEOUT-1 with lock_s=0: error<=1, cur_profile<=tgt (no automatic retry loop), go to DONE.
- DONE: one cycle; vdc_hold<=0, busy<=0, counters cleared, go to IDLE.
- Request handling:
  - sel changes while busy are not aborted; IDLE re-evaluates sel_s after DONE.
  - Toggling back to the old value mid-sequence still completes the sequence, then a second sequence returns the PLL to it.
- error is cleared only by a successful lock or by reset.
- Reset mid-sequence: all outputs return to reset values immediately (async), including mgmt_write=0. cur_profile=0 matches the PLL power-up configuration because the PLL itself is also reset.
- Counters: SETTLE counter 8 bits; timeout counter 20 bits; both saturate, never wrap.

Test Plan:
- Reset, sel=0, lock=1 -> no mgmt_write for 1000 cycles; busy=0, vdc_hold=0, cur_profile=0.
- sel 0->1, waitrequest=0, lock=1 -> writes (0x00,0), (0x04,0x20605), (0x07,0x851EB852), (0x05,0x1212), (0x02,1) in order, each write 1 cycle with 1 idle cycle between; lock sampled after 64 settle cycles; cur_profile=1 and busy=0 within 2 cycles of lock.
- waitrequest held high 5 cycles on the WR_K write -> address and data stable all 6 cycles; exactly one write is accepted.
- sel 0->1 with lock held low -> error=1, vdc_hold=0, cur_profile=1 at LOCK_TIMEOUT+SETTLE_CYC+~12 cycles; then sel 1->0 with lock high -> error=0.
- sel toggles 0->1->0 during WR_M -> first sequence completes (cur_profile=1), then a second sequence writes C0 word 0x909 and ends with cur_profile=0.
- reset_n low during WR_C with mgmt_write=1 -> mgmt_write=0 and busy=0 asynchronously; after release with sel=1, a full sequence restarts from WR_MODE.
